// File: rtl/bcd_seg_display.sv
// Binary-to-BCD converter (double-dabble, one shift per clock) feeding a
// three-digit multiplexed active-low 7-segment display with leading-zero blanking.
module bcd_seg_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] VALUE,
  output logic [6:0] SEG,
  output logic [2:0] AN,
  output logic [11:0] BCD,
  output logic       BUSY
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  state_e        state_q;
  logic [19:0]   sr_q;
  logic [19:0]   sr_adj;
  logic [2:0]    cnt_q;
  logic [11:0]   bcd_q;
  logic          busy_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic [3:0]    digit;
  logic          blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8+4*i +: 4] >= 4'd5) sr_adj[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sr_q    <= {12'b0, VALUE};
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          sr_q  <= {sr_adj[18:0], 1'b0};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= LOAD;
        end
        LOAD: begin
          bcd_q   <= sr_q[19:8];
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    digit = bcd_q[3:0];
    an_d  = 3'b110;
    blank = 1'b0;
    case (idx_q)
      2'd1: begin
        digit = bcd_q[7:4];
        an_d  = 3'b101;
        blank = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit = bcd_q[11:8];
        an_d  = 3'b011;
        blank = BLANK_LZ && (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg_d = seg7(digit);
    if (blank) begin
      an_d  = 3'b111;
      seg_d = 7'b1111111;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= 3'b111;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign BCD  = bcd_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Bench for bcd_seg_display: a cycle-phase model feeds a BCD scoreboard and
// per-scenario tasks check reset, conversion, scan, blanking and mid-flight events.
module tb_bcd_seg_display;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  VALUE = 8'd42;
  logic [6:0]  seg0, seg1;
  logic [2:0]  an0, an1;
  logic [11:0] bcd0, bcd1;
  logic        busy0, busy1;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] SEGTAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bcd_seg_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u0 (
    .CLK(CLK), .RST(RST), .VALUE(VALUE),
    .SEG(seg0), .AN(an0), .BCD(bcd0), .BUSY(busy0));

  bcd_seg_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u1 (
    .CLK(CLK), .RST(RST), .VALUE(VALUE),
    .SEG(seg1), .AN(an1), .BCD(bcd1), .BUSY(busy1));

  always #5 CLK = ~CLK;

  function automatic logic [11:0] exp_bcd(input int v);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    return {4'(h), 4'(t), 4'(o)};
  endfunction

  // {AN, SEG} expected for scan slot m showing value v.
  function automatic logic [9:0] exp_disp(input int v, input bit blz, input int m);
    int h, t, o, d;
    logic [2:0] an;
    bit blank;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    d = o; an = 3'b110; blank = 1'b0;
    if (m == 1) begin d = t; an = 3'b101; blank = blz && h == 0 && t == 0; end
    if (m == 2) begin d = h; an = 3'b011; blank = blz && h == 0; end
    if (blank) return {3'b111, 7'b1111111};
    return {an, SEGTAB[d]};
  endfunction

  // Phase model: ph is the phase of the next edge (0 = sampling edge).
  int ph = 0;
  int last_ph = -1;
  int ecnt = 0;
  logic [11:0] sbq [$];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ph = 0; last_ph = -1; ecnt = 0;
      sbq.delete();
    end else begin
      last_ph = ph;
      ecnt++;
      if (ph == 0) sbq.push_back(exp_bcd(int'(VALUE)));
      ph = (ph + 1) % 10;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      logic exp_busy;
      logic [11:0] e;
      exp_busy = (last_ph >= 0 && last_ph <= 8);
      checks++;
      if (busy0 !== exp_busy || busy1 !== exp_busy) begin
        failures++;
        $display("FAIL busy_sb t=%0t got=%b/%b exp=%b", $time, busy0, busy1, exp_busy);
      end
      if (last_ph == 9) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL bcd_sb_empty t=%0t got=%h", $time, bcd0);
        end else begin
          e = sbq.pop_front();
          if (bcd0 !== e || bcd1 !== e) begin
            failures++;
            $display("FAIL bcd_sb t=%0t got=%h/%h exp=%h", $time, bcd0, bcd1, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (seg0 !== 7'h7F || an0 !== 3'b111 || bcd0 !== 12'h000 || busy0 !== 1'b0 ||
          seg1 !== 7'h7F || an1 !== 3'b111) begin
        failures++;
        $display("FAIL reset_hold got seg=%b an=%b bcd=%h busy=%b exp 7F/111/000/0",
                 seg0, an0, bcd0, busy0);
      end
    end
    RST = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (i == 9) begin
        checks++;
        if (bcd0 !== 12'h000) begin
          failures++;
          $display("FAIL reset_lat9 got=%h exp=000", bcd0);
        end
      end
    end
    checks++;
    if (bcd0 !== 12'h042) begin
      failures++;
      $display("FAIL reset_lat10 got=%h exp=042", bcd0);
    end
  endtask

  task automatic test_conversion();
    int vals [7] = '{255, 0, 9, 10, 99, 100, 128};
    logic [11:0] exps [7] = '{12'h255, 12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
    int bc;
    foreach (vals[n]) begin
      for (int k = 0; k < 12 && ph != 0; k++) @(negedge CLK);
      checks++;
      if (ph != 0) begin
        failures++;
        $display("FAIL conv_align got_phase=%0d exp=0", ph);
      end
      VALUE = 8'(vals[n]);
      bc = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK);
        if (busy0 === 1'b1) bc++;
      end
      checks++;
      if (bcd0 !== exps[n] || bc != 9) begin
        failures++;
        $display("FAIL conv_%0d got bcd=%h busy_cycles=%0d exp bcd=%h busy_cycles=9",
                 vals[n], bcd0, bc, exps[n]);
      end
    end
  endtask

  task automatic test_scan();
    logic [9:0] e0, e1;
    int m;
    VALUE = 8'd123;
    repeat (25) @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      m = ((ecnt - 1) / 4) % 3;
      e0 = exp_disp(123, 1'b1, m);
      e1 = exp_disp(123, 1'b0, m);
      checks++;
      if ({an0, seg0} !== e0 || {an1, seg1} !== e1) begin
        failures++;
        $display("FAIL scan_123 slot=%0d got an/seg=%b/%b,%b/%b exp=%b/%b",
                 m, an0, seg0, an1, seg1, e1[9:7], e1[6:0]);
      end
    end
  endtask

  task automatic test_blanking();
    int vals [2] = '{7, 105};
    logic [9:0] e0, e1;
    int m;
    foreach (vals[n]) begin
      VALUE = 8'(vals[n]);
      repeat (25) @(negedge CLK);
      for (int i = 0; i < 12; i++) begin
        @(negedge CLK);
        m = ((ecnt - 1) / 4) % 3;
        e0 = exp_disp(vals[n], 1'b1, m);
        e1 = exp_disp(vals[n], 1'b0, m);
        checks++;
        if ({an0, seg0} !== e0) begin
          failures++;
          $display("FAIL blank_lz1_%0d slot=%0d got=%b/%b exp=%b/%b",
                   vals[n], m, an0, seg0, e0[9:7], e0[6:0]);
        end
        checks++;
        if ({an1, seg1} !== e1) begin
          failures++;
          $display("FAIL blank_lz0_%0d slot=%0d got=%b/%b exp=%b/%b",
                   vals[n], m, an1, seg1, e1[9:7], e1[6:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12 && ph != 0; k++) @(negedge CLK);
    VALUE = 8'd200;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (i == 3) VALUE = 8'd201;
    end
    checks++;
    if (bcd0 !== 12'h200) begin
      failures++;
      $display("FAIL midchange_first got=%h exp=200", bcd0);
    end
    repeat (10) @(negedge CLK);
    checks++;
    if (bcd0 !== 12'h201) begin
      failures++;
      $display("FAIL midchange_second got=%h exp=201", bcd0);
    end
  endtask

  task automatic test_reset_mid_shift();
    for (int k = 0; k < 12 && ph != 0; k++) @(negedge CLK);
    VALUE = 8'd77;
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (seg0 !== 7'h7F || an0 !== 3'b111 || bcd0 !== 12'h000 || busy0 !== 1'b0 ||
        seg1 !== 7'h7F || an1 !== 3'b111 || bcd1 !== 12'h000 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got seg=%b an=%b bcd=%h busy=%b exp 7F/111/000/0",
               seg0, an0, bcd0, busy0);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    checks++;
    if (bcd0 !== 12'h077 || bcd1 !== 12'h077) begin
      failures++;
      $display("FAIL reset_recover got=%h/%h exp=077", bcd0, bcd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_conversion();
    test_scan();
    test_blanking();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
